strobe_gen: RTL

Parametrised phase-accumulator strobe generator. It produces a one-cycle enable strobe at an average rate of f_clk*INC/2^ACC_W. The increment is run-time programmable through a valid/ready handshake, and a new increment takes effect only at a strobe boundary, so the strobe pattern never glitches. A modulo strobe counter with a wrap pulse drives pixel/line timing downstream, e.g. 25 MHz pixel enable plus 800-pixel line wrap from the 100 MHz board clock.

---
 rtl/strobe_gen.sv | 94 +++++++++
 1 files changed

// File: rtl/strobe_gen.sv
// Phase-accumulator strobe generator with a handshake-loaded increment and a modulo strobe counter.
// Optional build macro PHASE_SYNC_EN adds a synchronous phase-clear input sync_clr.
module strobe_gen #(
  parameter int               ACC_W   = 16,
  parameter logic [ACC_W-1:0] DEF_INC = 16'h4000,
  parameter int               CNT_W   = 10,
  parameter int               CNT_MAX = 799
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             inc_valid,
  output logic             inc_ready,
`ifdef PHASE_SYNC_EN
  input  logic             sync_clr,
`endif
  output logic             stb,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  typedef enum logic {RUN, PEND} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, inc_cur, pend;
  logic [ACC_W:0]   sum;
  logic             carry, xfer, swap, pend_vld, at_max, clr;

`ifdef PHASE_SYNC_EN
  assign clr = sync_clr;
`else
  assign clr = 1'b0;
`endif

  assign pend_vld  = (state == PEND);
  assign inc_ready = !pend_vld;
  assign xfer      = inc_valid && inc_ready;
  assign sum       = {1'b0, acc} + {1'b0, inc_cur};
  assign carry     = sum[ACC_W];
  assign at_max    = (cnt == CNT_W'(CNT_MAX));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    case (state)
      RUN:  if (xfer) state_nxt = PEND;
      // The swap waits for a strobe boundary so the running pattern never glitches;
      // while frozen there is no boundary to wait for.
      PEND: if (!clr && (!en || carry)) begin
        swap      = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      inc_cur <= DEF_INC;
      pend    <= '0;
      stb     <= 1'b0;
      cnt     <= '0;
      wrap    <= 1'b0;
    end else begin
      if (xfer) pend <= inc_in;
      // The carry edge still adds the old increment; the new one applies from the next edge.
      if (swap) inc_cur <= pend;
      if (clr) begin
        acc  <= '0;
        cnt  <= '0;
        stb  <= 1'b0;
        wrap <= 1'b0;
      end else if (en) begin
        acc  <= sum[ACC_W-1:0];
        stb  <= carry;
        wrap <= carry && at_max;
        if (carry) cnt <= at_max ? '0 : cnt + CNT_W'(1);
      end else begin
        stb  <= 1'b0;
        wrap <= 1'b0;
      end
    end
  end

endmodule
